// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 keyboard MMIO block:
// register offsets, STATUS bit positions, receiver states.
package kbd_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;

  localparam int ST_FULL = 0;
  localparam int ST_OVF  = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_CNT  = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, frame FSM, timeout.
// Ports: clk, rstn, ps2_clk, ps2_data in; rx_byte, byte_vld, frame_err out.
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_prev;
  logic          fall;
  logic          d;

  rx_state_t     state, state_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_ok, par_n;
  logic [TW-1:0] tmo, tmo_n;

  // Sync flops reset high so no edge is seen right after reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[1];
  assign d       = dat_sync[1];
  assign rx_byte = shreg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_ok  <= 1'b0;
      tmo     <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      par_ok  <= par_n;
      tmo     <= tmo_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_n     = bit_cnt;
    shreg_n   = shreg;
    par_n     = par_ok;
    tmo_n     = tmo;
    byte_vld  = 1'b0;
    frame_err = 1'b0;

    if (state == RX_IDLE || fall) begin
      tmo_n = '0;
    end else if (tmo == TW'(TIMEOUT - 1)) begin
      tmo_n     = '0;
      state_n   = RX_IDLE;
      frame_err = 1'b1;
    end else begin
      tmo_n = tmo + 1'b1;
    end

    if (fall) begin
      unique case (state)
        RX_IDLE: begin
          if (!d) begin
            state_n = RX_DATA;
            bit_n   = '0;
          end
        end
        RX_DATA: begin
          shreg_n = {d, shreg[7:1]};
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = RX_PARITY;
        end
        RX_PARITY: begin
          // odd parity: data bits plus parity bit hold an odd count of ones
          par_n   = ^{shreg, d};
          state_n = RX_STOP;
        end
        RX_STOP: begin
          state_n = RX_IDLE;
          if (d && par_ok) byte_vld  = 1'b1;
          else             frame_err = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/kbd_mmio.sv
// PS/2 keyboard MMIO device: scancode FIFO, DATA/STATUS regs, sticky flags.
// Ports: clk, rstn, sel, re, addr[3:0], ps2_clk, ps2_data in; dout[31:0] out.
module kbd_mmio
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sel,
  input  logic        re,
  input  logic [3:0]  addr,
  output logic [31:0] dout,
  input  logic        ps2_clk,
  input  logic        ps2_data
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    rx_byte;
  logic          byte_vld;
  logic          frame_err;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          err, ovf;

  logic          empty, full;
  logic          rd_data, rd_stat;
  logic          push, pop;
  logic [7:0]    head;
  logic [7:0]    cnt8;

  ps2_rx #(
    .TIMEOUT(TIMEOUT)
  ) u_rx (
    .clk      (clk),
    .rstn     (rstn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .byte_vld (byte_vld),
    .frame_err(frame_err)
  );

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign rd_data = sel && re && (addr == OFF_DATA);
  assign rd_stat = sel && re && (addr == OFF_STATUS);
  assign pop     = rd_data && !empty;
  // a pop on the same edge frees the slot, so a full FIFO still accepts
  assign push    = byte_vld && (!full || pop);
  assign head    = empty ? 8'h00 : mem[rptr];
  assign cnt8    = 8'(count);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {AW'(0), push} - {AW'(0), pop};
      // new events win over a clearing STATUS read
      if (frame_err)    err <= 1'b1;
      else if (rd_stat) err <= 1'b0;
      if (byte_vld && full && !pop) ovf <= 1'b1;
      else if (rd_stat)             ovf <= 1'b0;
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      OFF_DATA: begin
        dout[8]   = !empty;
        dout[7:0] = head;
      end
      OFF_STATUS: begin
        dout[ST_CNT+7:ST_CNT] = cnt8;
        dout[ST_ERR]          = err;
        dout[ST_OVF]          = ovf;
        dout[ST_FULL]         = full;
      end
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_kbd_mmio.sv
// Bench for kbd_mmio: directed scenarios plus random traffic,
// checked against a queue-based model of the device registers.
module tb_kbd_mmio;

  localparam int DEPTH = 8;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sel = 1'b0;
  logic        re = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] dout;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic       m_err = 1'b0;
  logic       m_ovf = 1'b0;

  kbd_mmio #(
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .sel     (sel),
    .re      (re),
    .addr    (addr),
    .dout    (dout),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_dout(input logic [3:0] a);
    logic [7:0] c;
    c = 8'(q.size());
    if (a == 4'h0)
      return (q.size() != 0) ? {23'b0, 1'b1, q[0]} : 32'h0;
    if (a == 4'h4)
      return {16'b0, c, 5'b0, m_err, m_ovf, (q.size() == DEPTH)};
    return 32'h0;
  endfunction

  task automatic check(input logic [31:0] got, input logic [31:0] exp,
                       input string tag);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic peek(input logic [3:0] a, input string tag);
    @(negedge clk);
    sel = 1'b0;
    re = 1'b0;
    addr = a;
    #1 check(dout, model_dout(a), tag);
  endtask

  task automatic rd(input logic [3:0] a, input string tag);
    @(negedge clk);
    sel = 1'b1;
    re = 1'b1;
    addr = a;
    #1 check(dout, model_dout(a), tag);
    @(posedge clk);
    #1;
    sel = 1'b0;
    re = 1'b0;
    if (a == 4'h0 && q.size() != 0) void'(q.pop_front());
    if (a == 4'h4) begin
      m_err = 1'b0;
      m_ovf = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b, input int hp);
    @(negedge clk) ps2_data = b;
    repeat (hp) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (hp) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // mode 0: plain, 1: latency probe (hp>=5), 2: DATA read on push edge
  task automatic send_frame(input logic [7:0] b, input logic bad,
                            input int hp, input int mode);
    logic p;
    p = (~^b) ^ bad;
    ps2_bit(1'b0, hp);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], hp);
    ps2_bit(p, hp);
    @(negedge clk) ps2_data = 1'b1;
    repeat (hp) @(negedge clk);
    ps2_clk = 1'b0;
    if (mode == 1) begin
      addr = 4'h0;
      @(negedge clk);
      @(negedge clk);
      #1 check(32'(dout[8]), 32'd0, "latency-2");
      @(negedge clk);
      #1 check(32'(dout[8]), 32'd1, "latency-3");
      repeat (hp - 3) @(negedge clk);
    end else if (mode == 2) begin
      @(negedge clk);
      @(negedge clk);
      sel = 1'b1;
      re = 1'b1;
      addr = 4'h0;
      #1 check(dout, model_dout(4'h0), "coincident-read");
      @(posedge clk);
      #1;
      sel = 1'b0;
      re = 1'b0;
      void'(q.pop_front());
      repeat (hp - 2) @(negedge clk);
    end else begin
      repeat (hp) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    if (bad)                   m_err = 1'b1;
    else if (q.size() == DEPTH) m_ovf = 1'b1;
    else                       q.push_back(b);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    addr = 4'h0;
    #1 check(dout, 32'h0, "reset-data");
    addr = 4'h4;
    #1 check(dout, 32'h0, "reset-status");
    addr = 4'h8;
    #1 check(dout, 32'h0, "reset-other");
    rstn = 1'b1;

    // single good frame with latency probe, then pop
    send_frame(8'h1C, 1'b0, 5, 1);
    check(model_dout(4'h0), 32'h0000011C, "model-1c");
    rd(4'h0, "data-1c");
    peek(4'h0, "data-after-pop");

    // bad parity: ERR set, then cleared by the STATUS read
    send_frame(8'h1C, 1'b1, 4, 0);
    rd(4'h4, "status-err");
    rd(4'h4, "status-cleared");

    // unmapped offset has no side effects
    send_frame(8'h77, 1'b0, 3, 0);
    rd(4'h8, "other-addr");
    rd(4'h0, "data-77");

    // overflow: nine frames into eight slots
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 3, 0);
    rd(4'h4, "status-ovf");
    for (int i = 0; i < 8; i++) rd(4'h0, "drain-ovf");
    rd(4'h0, "empty-read");
    rd(4'h4, "status-empty");

    // push and pop on the same edge while full
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 3, 0);
    send_frame(8'h09, 1'b0, 4, 2);
    rd(4'h4, "status-full-nopov");
    for (int i = 0; i < 8; i++) rd(4'h0, "drain-full");

    // slow but legal bit timing just under the timeout
    send_frame(8'hA5, 1'b0, TMO / 2 - 4, 0);
    rd(4'h0, "data-slow");

    // abandoned frame: start + 4 data bits, then silence
    ps2_bit(1'b0, 4);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 4);
    @(negedge clk) ps2_data = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    addr = 4'h4;
    for (int i = 1; i <= 66; i++) begin
      @(negedge clk);
      if (i == 4) ps2_clk = 1'b1;
    end
    #1 check(32'(dout[2]), 32'd0, "tmo-early");
    @(negedge clk);
    #1 check(32'(dout[2]), 32'd1, "tmo-fire");
    ps2_data = 1'b1;
    m_err = 1'b1;
    rd(4'h4, "status-tmo");
    send_frame(8'hF0, 1'b0, 5, 0);
    rd(4'h0, "data-f0");

    // reset in the middle of a frame
    send_frame(8'h33, 1'b0, 3, 0);
    ps2_bit(1'b0, 3);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1, 3);
    @(negedge clk) rstn = 1'b0;
    q.delete();
    m_err = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);
    addr = 4'h0;
    #1 check(dout, 32'h0, "rst-mid-data");
    addr = 4'h4;
    #1 check(dout, 32'h0, "rst-mid-status");
    @(negedge clk) rstn = 1'b1;
    send_frame(8'h5A, 1'b0, 4, 0);
    check(model_dout(4'h0), 32'h0000015A, "model-5a");
    rd(4'h0, "data-5a");

    // random traffic against the model
    for (int k = 0; k < 60; k++) begin
      int op;
      op = $urandom_range(0, 3);
      case (op)
        0, 1: send_frame(8'($urandom), ($urandom_range(0, 5) == 0),
                         $urandom_range(2, 6), 0);
        2: rd(4'h0, "rnd-data");
        default: rd(($urandom_range(0, 1) != 0) ? 4'h4
                     : 4'($urandom_range(8, 15)), "rnd-reg");
      endcase
    end
    rd(4'h4, "final-status");
    while (q.size() != 0) rd(4'h0, "final-drain");
    rd(4'h0, "final-empty");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
